// File: rtl/fpu_hazard_scoreboard.sv
// fpu_hazard_scoreboard: per-FP-register writeback countdowns that stall decode on RAW/WAW hazards.
// Optional stall-cycle statistics counter enabled by defining FPU_HAZARD_STATS_EN.
module fpu_hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int CNT_W   = 2,
  parameter int MAX_LAT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dec_valid,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        reg_write,
  input  logic        is_hazard_0,
  input  logic        is_hazard_1,
  input  logic        is_hazard_2,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        stall,
  output logic        pending_any,
  output logic [31:0] stall_count
);
  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] lat;
  logic             raw, waw, issue;
  assign lat   = is_hazard_2 ? CNT_W'(MAX_LAT) : is_hazard_1 ? CNT_W'(2) : is_hazard_0 ? CNT_W'(1) : '0;
  assign raw   = (use_rs1 && cnt[rs1] != '0) || (use_rs2 && cnt[rs2] != '0);
  // a younger short op must not retire before an older long op to the same rd
  assign waw   = reg_write && (cnt[rd] > lat);
  assign stall = dec_valid && !flush && (raw || waw);
  assign issue = dec_valid && !flush && !stall && !pipe_stall && reg_write;
  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < NREG; i++) pending_any = pending_any | (cnt[i] != '0);
  end
  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt[i] <= '0;
      else if (!pipe_stall) cnt[i] <= (issue && rd == 5'(i)) ? lat : (cnt[i] != '0 ? cnt[i] - 1'b1 : '0);
  end
`ifdef FPU_HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) stall_cnt <= '0;
    else if (stall && !pipe_stall) stall_cnt <= stall_cnt + 32'd1;
  assign stall_count = stall_cnt;
`else
  assign stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_fpu_hazard_scoreboard.sv
// tb_fpu_hazard_scoreboard: directed scenarios for the FP hazard scoreboard with hand-derived stall/pending expectations.
module tb_fpu_hazard_scoreboard;
  logic clk = 1'b0, rstn = 1'b0;
  logic dec_valid, use_rs1, use_rs2, reg_write, flush, pipe_stall;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] hz;
  logic stall, pending_any;
  logic [31:0] stall_count;
  int tests = 0, fails = 0;
  logic [31:0] exp_sc = 32'd0;
  fpu_hazard_scoreboard dut (
    .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .reg_write(reg_write),
    .is_hazard_0(hz[0]), .is_hazard_1(hz[1]), .is_hazard_2(hz[2]),
    .flush(flush), .pipe_stall(pipe_stall),
    .stall(stall), .pending_any(pending_any), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic ins(input logic v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                     input logic u1, input logic u2, input logic w, input logic [2:0] h,
                     input logic fl, input logic ps);
    dec_valid = v; rs1 = a; rs2 = b; rd = d; use_rs1 = u1; use_rs2 = u2;
    reg_write = w; hz = h; flush = fl; pipe_stall = ps;
  endtask
  task automatic idle();
    ins(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
  endtask
  task automatic cyc(input string tag, input logic es, input logic ep);
    #1;
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, es});
    chk({tag, ".pend"}, {31'd0, pending_any}, {31'd0, ep});
`ifdef FPU_HAZARD_STATS_EN
    if (es && !pipe_stall) exp_sc = exp_sc + 32'd1;
`endif
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    @(posedge clk); @(posedge clk); #1;
    ins(1, 3, 3, 3, 1, 1, 1, 3'b111, 0, 0);
    #1;
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.pend", {31'd0, pending_any}, 32'd0);
    chk("rst.sc", stall_count, 32'd0);
    idle();
    rstn = 1'b1;
    @(posedge clk); #1;
    ins(1, 0, 0, 3, 0, 0, 1, 3'b011, 0, 0);  cyc("s1.fmul", 0, 0);
    ins(1, 3, 0, 10, 1, 0, 1, 3'b001, 0, 0); cyc("s1.st1", 1, 1);
    cyc("s1.st2", 1, 1);
    cyc("s1.iss", 0, 0);
    idle(); cyc("s1.p1", 0, 1);
    cyc("s1.p0", 0, 0);
    chk("s1.sc", stall_count, exp_sc);
    ins(1, 0, 0, 5, 0, 0, 1, 3'b001, 0, 0);  cyc("s2.fadd", 0, 0);
    ins(1, 6, 7, 8, 1, 1, 1, 3'b000, 0, 0);  cyc("s2.fsgnj", 0, 1);
    idle(); cyc("s2.idle", 0, 0);
    ins(1, 0, 0, 4, 0, 0, 1, 3'b010, 0, 0);  cyc("s3.fmul", 0, 0);
    ins(1, 0, 0, 4, 0, 0, 1, 3'b000, 0, 0);  cyc("s3.waw1", 1, 1);
    cyc("s3.waw2", 1, 1);
    cyc("s3.iss", 0, 0);
    idle(); cyc("s3.idle", 0, 0);
    ins(1, 0, 0, 9, 0, 0, 1, 3'b100, 0, 0);  cyc("l3.prod", 0, 0);
    ins(1, 0, 0, 9, 0, 0, 1, 3'b010, 0, 0);  cyc("l3.waw", 1, 1);
    cyc("l3.iss", 0, 1);
    idle(); cyc("l3.c2", 0, 1);
    cyc("l3.c1", 0, 1);
    cyc("l3.c0", 0, 0);
    ins(1, 0, 0, 12, 0, 0, 1, 3'b100, 0, 1); cyc("ps.noiss", 0, 0);
    idle(); cyc("ps.after", 0, 0);
    ins(1, 0, 0, 3, 0, 0, 1, 3'b010, 0, 0);  cyc("s4.prod", 0, 0);
    for (int i = 0; i < 3; i++) begin
      ins(1, 3, 0, 11, 1, 0, 0, 3'b000, 0, 1); cyc("s4.hold", 1, 1);
    end
    chk("s4.sc", stall_count, exp_sc);
    ins(1, 3, 0, 11, 1, 0, 0, 3'b000, 0, 0); cyc("s4.st1", 1, 1);
    cyc("s4.st2", 1, 1);
    cyc("s4.iss", 0, 0);
    ins(1, 0, 0, 8, 0, 0, 1, 3'b001, 0, 0);  cyc("s5.prod", 0, 0);
    ins(1, 0, 8, 13, 0, 1, 1, 3'b010, 1, 0); cyc("s5.flush", 0, 1);
    idle(); cyc("s5.after", 0, 0);
    ins(1, 0, 0, 14, 0, 0, 1, 3'b001, 0, 0);  cyc("dup.prod", 0, 0);
    ins(1, 14, 14, 0, 1, 1, 0, 3'b000, 0, 0); cyc("dup.st", 1, 1);
    cyc("dup.go", 0, 0);
    ins(1, 0, 0, 15, 0, 0, 1, 3'b001, 0, 0);  cyc("rdrs.prod", 0, 0);
    ins(1, 15, 0, 15, 1, 0, 1, 3'b010, 0, 0); cyc("rdrs.st", 1, 1);
    cyc("rdrs.iss", 0, 0);
    idle(); cyc("rdrs.c2", 0, 1);
    cyc("rdrs.c1", 0, 1);
    cyc("rdrs.c0", 0, 0);
    ins(1, 0, 0, 3, 0, 0, 1, 3'b011, 0, 0);  cyc("s6.prod", 0, 0);
    ins(0, 3, 0, 0, 1, 0, 0, 3'b000, 0, 0);  cyc("s6.novalid", 0, 1);
    ins(1, 3, 0, 0, 1, 0, 0, 3'b000, 0, 0);  cyc("s6.st", 1, 1);
    ins(1, 0, 0, 3, 0, 0, 1, 3'b100, 0, 0);  cyc("s6.prod2", 0, 0);
    ins(1, 3, 0, 0, 1, 0, 0, 3'b000, 0, 0);  cyc("s6.st2", 1, 1);
    chk("s6.sc", stall_count, exp_sc);
    #1 rstn = 1'b0;
    #1;
    chk("arst.stall", {31'd0, stall}, 32'd0);
    chk("arst.pend", {31'd0, pending_any}, 32'd0);
    chk("arst.sc", stall_count, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc("post.rst", 0, 0);
    chk("post.sc", stall_count, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpu_hazard_scoreboard.md
Name: fpu_hazard_scoreboard

Overview:
- Sits directly downstream of the FPU decode/control decoder, in the decode/issue stage.
- Consumes the decoded FP control bits (reg_write, use_rs1, use_rs2, is_hazard_0/1/2) and the instruction register fields.
- Tracks, per FP register, the cycles remaining until an in-flight result is written back.
- Raises a stall to hold decode on RAW and WAW hazards against multi-cycle FPU ops and FP loads.

Parameters:
- NREG, 32, number of FP architectural registers tracked (f0 is a real register and is tracked).
- CNT_W, 2, width of each per-register countdown; must hold MAX_LAT.
- MAX_LAT, 3, largest latency class encoded by is_hazard_*.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- dec_valid  input  1  decode stage holds a valid instruction.
- rs1  input  5  FP source register 1 index.
- rs2  input  5  FP source register 2 index.
- rd  input  5  FP destination register index.
- use_rs1  input  1  instruction reads rs1 from the FP register file.
- use_rs2  input  1  instruction reads rs2 from the FP register file.
- reg_write  input  1  instruction writes rd in the FP register file.
- is_hazard_0  input  1  result unavailable for at least 1 extra cycle.
- is_hazard_1  input  1  result unavailable for at least 2 extra cycles.
- is_hazard_2  input  1  result unavailable for at least 3 extra cycles.
- flush  input  1  kill the decode-stage instruction (branch redirect).
- pipe_stall  input  1  global pipeline freeze (memory stall etc.).
- stall  output  1  hold decode; combinational.
- pending_any  output  1  any counter nonzero; combinational.
- stall_count  output  32  stall-cycle counter (see Optional Feature).

Behaviour:
- State: cnt[0..NREG-1], CNT_W bits each.
- Reset (rstn low, async): all cnt = 0. stall_count = 0. stall = 0 and pending_any = 0 while reset is held.
- Latency class: lat = 3 if is_hazard_2, else 2 if is_hazard_1, else 1 if is_hazard_0, else 0. Priority holds for any input combination.
- RAW = (use_rs1 & cnt[rs1] != 0) | (use_rs2 & cnt[rs2] != 0).
- WAW = reg_write & (cnt[rd] > lat). This keeps writeback order: a younger short op never overtakes an older long op to the same rd.
- stall = dec_valid & ~flush & (RAW | WAW). No dependence on pipe_stall, so there is no combinational loop.
- issue = dec_valid & ~flush & ~stall & ~pipe_stall & reg_write.
- Each rising edge with pipe_stall = 0:
  - every cnt[i] != 0 decrements by 1;
  - if issue, cnt[rd] <= lat. This overrides the decrement of the same entry in the same cycle.
- Edge with pipe_stall = 1: all counters hold, and no issue occurs.
- lat = 0 issue writes cnt[rd] = 0. This is legal, because the WAW rule guaranteed the old cnt[rd] was 0.
- Effective timing: a consumer in the cycle after a lat = L producer stalls exactly L cycles, then issues.
- rs1 == rs2 == pending reg: counts as one hazard, with no double effect.
- rd == rs1 on the same instruction: RAW is checked against the old cnt, before the update.
- flush: suppresses stall and issue for that cycle only. Counters for already-issued ops keep counting, because in-flight ops still complete.
- Reset asserted mid-operation: all pending state is discarded immediately.
- Counters saturate at 0 and never wrap below 0.
- pending_any = OR of all cnt != 0.

Optional Feature:
- Macro: FPU_HAZARD_STATS_EN.
- Defined: stall_count increments on every edge where stall = 1 and pipe_stall = 0, wraps modulo 2^32, and is cleared by reset.
- Not defined: no counter register exists and stall_count is tied to 32'd0.

Test Plan:
- Reset, then fmul f3 (is_hazard_0=1, is_hazard_1=1, lat=2). Next cycle, fadd reads rs1=f3 -> stall=1 for exactly 2 cycles, fadd issues on cycle 3, cnt[3] = 0 on issue.
- fadd f5 (lat=1), then fsgnj reading f6/f7 (no dependency) -> stall stays 0 and both issue back to back.
- fmul f4 (lat=2), then next cycle fsgnj writing rd=f4 (lat=0), no source use -> WAW stall for 2 cycles, then issue.
- Dependent fadd on f3 stalled with cnt[3]=2. Assert pipe_stall for 3 cycles -> cnt[3] holds at 2. After release -> 2 more stall cycles.
- cnt[8]=1 and dependent instruction present, flush=1 -> stall=0 and no issue. Next edge -> cnt[8]=0 and pending_any=0.
- With FPU_HAZARD_STATS_EN, run the first scenario -> stall_count=2. Assert rstn=0 asynchronously mid-stall -> stall_count=0, pending_any=0, stall=0 immediately.
